// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush controller with mult/div busy tracking
// Derives register en/clr per stage from load-use, branch and mult/div hazards and M-stage exceptions.
module pipe_hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  RsD,
  input  logic [4:0]  RtD,
  input  logic        RsUseD,
  input  logic        RtUseD,
  input  logic        BranchD,
  input  logic        MdUseD,
  input  logic [4:0]  RegAddrE,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic [4:0]  RegAddrM,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic        MdStartE,
  input  logic        MdOpE,
  input  logic        ExcOccurM,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        ClrD,
  output logic        ClrE,
  output logic        ClrM,
  output logic        ClrW,
  output logic        PCExc,
  output logic        MdStartOK,
  output logic        MdBusy,
  output logic [31:0] StallCnt
);

  localparam int MAX_CYC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
  localparam int CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYC);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } md_state_t;

  md_state_t        state;
  md_state_t        state_next;
  logic [CNT_W-1:0] md_cnt;
  logic [CNT_W-1:0] md_cnt_next;
  logic [CNT_W-1:0] md_load;
  logic [31:0]      stall_cnt;

  logic e_hit;
  logic m_hit;
  logic load_use;
  logic branch_haz;
  logic start_ok;
  logic busy;
  logic md_haz;
  logic stall;

  // Register 0 is hardwired, so a zero destination never matches.
  assign e_hit = (RegAddrE != 5'd0) &&
                 ((RsUseD && (RsD == RegAddrE)) || (RtUseD && (RtD == RegAddrE)));
  assign m_hit = (RegAddrM != 5'd0) &&
                 ((RsUseD && (RsD == RegAddrM)) || (RtUseD && (RtD == RegAddrM)));

  assign load_use   = RegWriteE && MemtoRegE && e_hit;
  assign branch_haz = BranchD && ((RegWriteE && e_hit) ||
                                  (RegWriteM && MemtoRegM && m_hit));

  // A start younger than the committing exception must never launch.
  assign start_ok = MdStartE && !ExcOccurM;
  assign busy     = start_ok || (md_cnt != '0);
  assign md_haz   = MdUseD && busy;
  assign stall    = load_use || branch_haz || md_haz;
  assign md_load  = MdOpE ? DIV_LOAD : MULT_LOAD;

  assign StallE   = 1'b0;
  assign StallM   = 1'b0;
  assign StallCnt = stall_cnt;

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    ClrD      = 1'b0;
    ClrE      = 1'b0;
    ClrM      = 1'b0;
    ClrW      = 1'b0;
    PCExc     = 1'b0;
    MdStartOK = 1'b0;
    MdBusy    = 1'b0;
    if (!reset) begin
      MdStartOK = start_ok;
      MdBusy    = busy;
      // Older instructions in W still retire, so ClrW stays low on an exception.
      if (ExcOccurM) begin
        ClrD  = 1'b1;
        ClrE  = 1'b1;
        ClrM  = 1'b1;
        PCExc = 1'b1;
      end else if (stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        ClrE   = 1'b1;
      end
    end
  end

  always_comb begin
    state_next  = state;
    md_cnt_next = md_cnt;
    case (state)
      S_IDLE: begin
        if (start_ok) begin
          md_cnt_next = md_load;
          state_next  = (md_load != '0) ? S_BUSY : S_IDLE;
        end
      end
      S_BUSY: begin
        // An in-flight operation is older than any exception and keeps counting.
        if (start_ok) begin
          md_cnt_next = md_load;
          state_next  = (md_load != '0) ? S_BUSY : S_IDLE;
        end else begin
          md_cnt_next = md_cnt - 1'b1;
          if (md_cnt == CNT_W'(1)) begin
            state_next = S_IDLE;
          end
        end
      end
      default: begin
        state_next  = S_IDLE;
        md_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      md_cnt    <= '0;
      stall_cnt <= 32'd0;
    end else begin
      state  <= state_next;
      md_cnt <= md_cnt_next;
      if (StallD && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  RsD, RtD, RegAddrE, RegAddrM;
  logic        RsUseD, RtUseD, BranchD, MdUseD;
  logic        RegWriteE, MemtoRegE, RegWriteM, MemtoRegM;
  logic        MdStartE, MdOpE, ExcOccurM;
  logic        StallF, StallD, StallE, StallM;
  logic        ClrD, ClrE, ClrM, ClrW, PCExc, MdStartOK, MdBusy;
  logic [31:0] StallCnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset(reset),
    .RsD(RsD), .RtD(RtD), .RsUseD(RsUseD), .RtUseD(RtUseD),
    .BranchD(BranchD), .MdUseD(MdUseD),
    .RegAddrE(RegAddrE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
    .RegAddrM(RegAddrM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .MdStartE(MdStartE), .MdOpE(MdOpE), .ExcOccurM(ExcOccurM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .ClrD(ClrD), .ClrE(ClrE), .ClrM(ClrM), .ClrW(ClrW), .PCExc(PCExc),
    .MdStartOK(MdStartOK), .MdBusy(MdBusy), .StallCnt(StallCnt)
  );

  // Packed order: {StallF, StallD, StallE, StallM, ClrD, ClrE, ClrM, ClrW, PCExc}
  localparam logic [8:0] O_NONE  = 9'b000000000;
  localparam logic [8:0] O_STALL = 9'b110001000;
  localparam logic [8:0] O_EXC   = 9'b000011101;

  typedef struct {
    string      name;
    logic [4:0] rs, rt;
    logic       rs_use, rt_use, branch, md_use;
    logic [4:0] ae;
    logic       we, me;
    logic [4:0] am;
    logic       wm, mm, exc;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [8:0] outs();
    return {StallF, StallD, StallE, StallM, ClrD, ClrE, ClrM, ClrW, PCExc};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    RsD = 0; RtD = 0; RsUseD = 0; RtUseD = 0; BranchD = 0; MdUseD = 0;
    RegAddrE = 0; RegWriteE = 0; MemtoRegE = 0;
    RegAddrM = 0; RegWriteM = 0; MemtoRegM = 0;
    MdStartE = 0; MdOpE = 0; ExcOccurM = 0;
  endtask

  task automatic load_use_inputs();
    idle_inputs();
    RsD = 5'd8; RsUseD = 1; RegAddrE = 5'd8; RegWriteE = 1; MemtoRegE = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    reset = 1;
    idle_inputs();
    tick();
    reset = 0;
  endtask

  task automatic add_vec(input string n, input logic [4:0] rs, input logic [4:0] rt,
                         input logic ru, input logic tu, input logic br, input logic md,
                         input logic [4:0] ae, input logic we, input logic me,
                         input logic [4:0] am, input logic wm, input logic mm,
                         input logic exc, input logic [8:0] exp);
    vec_t v;
    v.name = n; v.rs = rs; v.rt = rt; v.rs_use = ru; v.rt_use = tu; v.branch = br;
    v.md_use = md; v.ae = ae; v.we = we; v.me = me; v.am = am; v.wm = wm; v.mm = mm;
    v.exc = exc; v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin
    //       name              rs  rt  ru tu br md  ae  we me  am  wm mm exc  exp
    add_vec("none",            0,  0,  0, 0, 0, 0,  0,  0, 0,  0,  0, 0, 0,  O_NONE);
    add_vec("lu_rs",           8,  0,  1, 0, 0, 0,  8,  1, 1,  0,  0, 0, 0,  O_STALL);
    add_vec("lu_r0",           0,  0,  1, 0, 0, 0,  0,  1, 1,  0,  0, 0, 0,  O_NONE);
    add_vec("lu_rs_unused",    8,  0,  0, 0, 0, 0,  8,  1, 1,  0,  0, 0, 0,  O_NONE);
    add_vec("lu_rt",           3,  9,  1, 1, 0, 0,  9,  1, 1,  0,  0, 0, 0,  O_STALL);
    add_vec("alu_e_nobr",      8,  0,  1, 0, 0, 0,  8,  1, 0,  0,  0, 0, 0,  O_NONE);
    add_vec("br_alu_e",        8,  0,  1, 0, 1, 0,  8,  1, 0,  0,  0, 0, 0,  O_STALL);
    add_vec("br_e_nowrite",    8,  0,  1, 0, 1, 0,  8,  0, 0,  0,  0, 0, 0,  O_NONE);
    add_vec("br_load_m_rt",    1,  9,  1, 1, 1, 0,  0,  0, 0,  9,  1, 1, 0,  O_STALL);
    add_vec("br_alu_m",        1,  9,  1, 1, 1, 0,  0,  0, 0,  9,  1, 0, 0,  O_NONE);
    add_vec("br_load_m_r0",    0,  0,  1, 1, 1, 0,  0,  0, 0,  0,  1, 1, 0,  O_NONE);
    add_vec("load_m_nobr",     9,  0,  1, 0, 0, 0,  0,  0, 0,  9,  1, 1, 0,  O_NONE);
    add_vec("exc_only",        0,  0,  0, 0, 0, 0,  0,  0, 0,  0,  0, 0, 1,  O_EXC);
    add_vec("exc_over_lu",     8,  0,  1, 0, 0, 0,  8,  1, 1,  0,  0, 0, 1,  O_EXC);
    add_vec("md_use_idle",     0,  0,  0, 0, 0, 1,  0,  0, 0,  0,  0, 0, 0,  O_NONE);

    reset = 1;
    idle_inputs();
    load_use_inputs();
    MdStartE = 1; MdUseD = 1;
    settle();
    check("reset_outs", 32'(outs()), 32'(O_NONE));
    check("reset_startok", 32'(MdStartOK), 32'd0);
    check("reset_busy", 32'(MdBusy), 32'd0);
    tick();
    settle();
    check("reset_stallcnt", StallCnt, 32'd0);
    check("reset_mdcnt", 32'(dut.md_cnt), 32'd0);
    tick();
    reset = 0;
    idle_inputs();

    // Combinational vectors with the mult/div unit idle.
    for (int i = 0; i < vecs.size(); i++) begin
      RsD = vecs[i].rs; RtD = vecs[i].rt; RsUseD = vecs[i].rs_use; RtUseD = vecs[i].rt_use;
      BranchD = vecs[i].branch; MdUseD = vecs[i].md_use;
      RegAddrE = vecs[i].ae; RegWriteE = vecs[i].we; MemtoRegE = vecs[i].me;
      RegAddrM = vecs[i].am; RegWriteM = vecs[i].wm; MemtoRegM = vecs[i].mm;
      ExcOccurM = vecs[i].exc; MdStartE = 0; MdOpE = 0;
      settle();
      check(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
      tick();
    end

    // Load-use: exactly one stall cycle counted.
    do_reset();
    load_use_inputs();
    settle();
    check("lu_seq_outs", 32'(outs()), 32'(O_STALL));
    tick();
    idle_inputs();
    RsD = 5'd8; RsUseD = 1; RegAddrM = 5'd8; RegWriteM = 1; MemtoRegM = 1;
    settle();
    check("lu_seq_release", 32'(outs()), 32'(O_NONE));
    check("lu_seq_cnt", StallCnt, 32'd1);

    // Branch after load: E match, then M load match, released on the third cycle.
    do_reset();
    BranchD = 1; RsD = 5'd9; RsUseD = 1; RegAddrE = 5'd9; RegWriteE = 1; MemtoRegE = 1;
    settle();
    check("brl_c1", 32'(StallD), 32'd1);
    tick();
    RegAddrE = 0; RegWriteE = 0; MemtoRegE = 0;
    RegAddrM = 5'd9; RegWriteM = 1; MemtoRegM = 1;
    settle();
    check("brl_c2", 32'(StallD), 32'd1);
    tick();
    RegAddrM = 0; RegWriteM = 0; MemtoRegM = 0;
    settle();
    check("brl_c3", 32'(StallD), 32'd0);
    check("brl_cnt", StallCnt, 32'd2);

    // Mult then mfhi: stalled t+1..t+5, released t+6.
    do_reset();
    MdStartE = 1; MdOpE = 0;
    settle();
    check("mult_startok", 32'(MdStartOK), 32'd1);
    check("mult_busy_t", 32'(MdBusy), 32'd1);
    tick();
    MdStartE = 0; MdUseD = 1;
    for (int k = 1; k <= 5; k++) begin
      settle();
      check($sformatf("mult_cnt_t%0d", k), 32'(dut.md_cnt), 32'(6 - k));
      check($sformatf("mult_stall_t%0d", k), 32'(StallD), 32'd1);
      tick();
    end
    settle();
    check("mult_release", 32'(StallD), 32'd0);
    check("mult_busy_t6", 32'(MdBusy), 32'd0);
    check("mult_stallcnt", StallCnt, 32'd5);

    // Div: released at t+11.
    do_reset();
    MdStartE = 1; MdOpE = 1;
    tick();
    MdStartE = 0; MdUseD = 1;
    for (int k = 1; k <= 10; k++) begin
      settle();
      check($sformatf("div_stall_t%0d", k), 32'(StallD), 32'd1);
      tick();
    end
    settle();
    check("div_release", 32'(StallD), 32'd0);
    check("div_busy_t11", 32'(MdBusy), 32'd0);

    // Exception during a load-use stall leaves StallCnt unchanged.
    do_reset();
    load_use_inputs();
    ExcOccurM = 1;
    settle();
    check("exc_lu_outs", 32'(outs()), 32'(O_EXC));
    tick();
    settle();
    check("exc_lu_cnt", StallCnt, 32'd0);

    // Exception kills a start.
    do_reset();
    MdStartE = 1; MdOpE = 1; ExcOccurM = 1;
    settle();
    check("exc_kill_startok", 32'(MdStartOK), 32'd0);
    check("exc_kill_busy", 32'(MdBusy), 32'd0);
    tick();
    idle_inputs();
    settle();
    check("exc_kill_cnt", 32'(dut.md_cnt), 32'd0);

    // In-flight div keeps counting through an exception.
    do_reset();
    MdStartE = 1; MdOpE = 1;
    tick();
    MdStartE = 0;
    for (int k = 0; k < 6; k++) tick();
    settle();
    check("inflight_cnt4", 32'(dut.md_cnt), 32'd4);
    ExcOccurM = 1;
    settle();
    check("inflight_busy", 32'(MdBusy), 32'd1);
    for (int k = 3; k >= 0; k--) begin
      tick();
      settle();
      check($sformatf("inflight_cnt%0d", k), 32'(dut.md_cnt), 32'(k));
    end

    // Reset mid-operation with MdCnt=7 and StallCnt=9.
    do_reset();
    load_use_inputs();
    for (int k = 0; k < 5; k++) tick();
    idle_inputs();
    MdStartE = 1; MdOpE = 1; MdUseD = 1;
    settle();
    check("mid_start_stall", 32'(StallD), 32'd1);
    tick();
    MdStartE = 0;
    for (int k = 0; k < 3; k++) tick();
    settle();
    check("mid_mdcnt7", 32'(dut.md_cnt), 32'd7);
    check("mid_stallcnt9", StallCnt, 32'd9);
    reset = 1;
    load_use_inputs();
    MdUseD = 1; MdStartE = 1; BranchD = 1;
    settle();
    check("mid_reset_outs", 32'(outs()), 32'(O_NONE));
    check("mid_reset_busy", 32'(MdBusy), 32'd0);
    check("mid_reset_startok", 32'(MdStartOK), 32'd0);
    tick();
    settle();
    check("mid_reset_mdcnt", 32'(dut.md_cnt), 32'd0);
    check("mid_reset_stallcnt", StallCnt, 32'd0);
    reset = 0;
    idle_inputs();

    // StallCnt saturation.
    do_reset();
    dut.stall_cnt = 32'hFFFF_FFFE;
    load_use_inputs();
    tick();
    settle();
    check("sat_reach", StallCnt, 32'hFFFF_FFFF);
    tick();
    settle();
    check("sat_hold", StallCnt, 32'hFFFF_FFFF);
    check("sat_stall", 32'(StallD), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
